// File: rtl/sa_ctrl.sv
// Sequencing controller for a systolic array: operand feed, pipeline flush, result drain.
// Optional drain watchdog enabled by defining SA_CTRL_TIMEOUT_EN.
module sa_ctrl #(
   parameter int ROWS      = 8,
   parameter int KW        = 8,
   parameter int FLUSH_CYC = 2*ROWS,
   parameter int TIMEOUT   = 64,
   localparam int IW = (ROWS > 1) ? $clog2(ROWS) : 1,
   localparam int CMAX = (FLUSH_CYC > TIMEOUT) ? FLUSH_CYC : TIMEOUT,
   localparam int CW = $clog2(CMAX + 1)
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            start,
   input  logic [KW-1:0]   k_len,
   output logic            busy,
   output logic            done,
   output logic            err,
   output logic            buf_rd_en,
   output logic [KW-1:0]   buf_rd_addr,
   output logic            core_inpvalid,
   output logic            core_outread,
   input  logic [ROWS-1:0] core_rvalid,
   input  logic            res_ready,
   output logic            res_wr,
   output logic [ROWS-1:0] res_wr_mask,
   output logic [IW-1:0]   res_idx
);

   typedef enum logic [2:0] {S_IDLE, S_FEED, S_FLUSH, S_DRAIN, S_DONE} state_t;

   state_t        state_reg, state_next;
   logic [KW-1:0] klen_reg, klen_next;
   logic [KW-1:0] addr_reg, addr_next;
   logic [CW-1:0] cnt_reg, cnt_next;
   logic [IW-1:0] idx_reg, idx_next;
   logic          inpvalid_reg;
   logic          hs;

`ifdef SA_CTRL_TIMEOUT_EN
   logic          err_reg, err_next;
`endif

   assign hs = (state_reg == S_DRAIN) && (|core_rvalid) && res_ready;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_reg    <= S_IDLE;
         klen_reg     <= '0;
         addr_reg     <= '0;
         cnt_reg      <= '0;
         idx_reg      <= '0;
         inpvalid_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         klen_reg     <= klen_next;
         addr_reg     <= addr_next;
         cnt_reg      <= cnt_next;
         idx_reg      <= idx_next;
         // Operand buffer has one cycle of read latency
         inpvalid_reg <= (state_reg == S_FEED);
      end
   end

`ifdef SA_CTRL_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (!rstn) err_reg <= 1'b0;
      else       err_reg <= err_next;
   end
`endif

   always_comb begin
      state_next = state_reg;
      klen_next  = klen_reg;
      addr_next  = addr_reg;
      cnt_next   = cnt_reg;
      idx_next   = idx_reg;
`ifdef SA_CTRL_TIMEOUT_EN
      err_next   = err_reg;
`endif
      case (state_reg)
         S_IDLE: begin
            addr_next = '0;
            cnt_next  = '0;
            idx_next  = '0;
`ifdef SA_CTRL_TIMEOUT_EN
            err_next  = 1'b0;
`endif
            if (start) begin
               klen_next  = k_len;
               state_next = (k_len != '0) ? S_FEED : S_DONE;
            end
         end
         S_FEED: begin
            if (addr_reg == klen_reg - 1'b1) begin
               cnt_next   = '0;
               state_next = S_FLUSH;
            end else begin
               addr_next = addr_reg + 1'b1;
            end
         end
         S_FLUSH: begin
            if (cnt_reg == CW'(FLUSH_CYC - 1)) begin
               cnt_next   = '0;
               state_next = S_DRAIN;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         S_DRAIN: begin
            if (hs) begin
               cnt_next = '0;
               if (idx_reg == IW'(ROWS - 1)) begin
                  idx_next   = '0;
                  state_next = S_DONE;
               end else begin
                  idx_next = idx_reg + 1'b1;
               end
            end
`ifdef SA_CTRL_TIMEOUT_EN
            else if (cnt_reg == CW'(TIMEOUT - 1)) begin
               idx_next   = '0;
               err_next   = 1'b1;
               state_next = S_DONE;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
`endif
         end
         S_DONE:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   assign busy          = (state_reg == S_FEED) || (state_reg == S_FLUSH) || (state_reg == S_DRAIN);
   assign done          = (state_reg == S_DONE);
   assign buf_rd_en     = (state_reg == S_FEED);
   assign buf_rd_addr   = (state_reg == S_FEED) ? addr_reg : '0;
   assign core_inpvalid = inpvalid_reg;
   assign core_outread  = hs;
   assign res_wr        = hs;
   assign res_wr_mask   = (state_reg == S_DRAIN) ? core_rvalid : '0;
   assign res_idx       = idx_reg;

`ifdef SA_CTRL_TIMEOUT_EN
   assign err = (state_reg == S_DONE) && err_reg;
`else
   assign err = 1'b0;
`endif

endmodule
